// File: rtl/test_pattern_gen_if.sv
// Pixel-side bundle for test_pattern_gen: timing/config inputs and colour outputs.
// One pixel per clock; there is no valid/ready pairing, every cycle carries a pixel.
interface test_pattern_gen_if #(
    parameter int BIT_WIDTH   = 12,
    parameter int BIT_HEIGHT  = 11,
    parameter int COLOR_DEPTH = 8
);
    logic [2:0]             mode;
    logic [BIT_WIDTH-1:0]   screen_width;
    logic [BIT_HEIGHT-1:0]  screen_height;
    logic [BIT_WIDTH-1:0]   cx;
    logic [BIT_HEIGHT-1:0]  cy;
    logic [COLOR_DEPTH-1:0] in_r;
    logic [COLOR_DEPTH-1:0] in_g;
    logic [COLOR_DEPTH-1:0] in_b;
    logic [COLOR_DEPTH-1:0] out_r;
    logic [COLOR_DEPTH-1:0] out_g;
    logic [COLOR_DEPTH-1:0] out_b;
    logic [15:0]            frame_count;
    logic                   bars_ready;
    logic [1:0]             div_state;

    modport master (
        output mode, screen_width, screen_height, cx, cy, in_r, in_g, in_b,
        input  out_r, out_g, out_b, frame_count, bars_ready, div_state
    );

    modport slave (
        input  mode, screen_width, screen_height, cx, cy, in_r, in_g, in_b,
        output out_r, out_g, out_b, frame_count, bars_ready, div_state
    );
endinterface

// File: rtl/test_pattern_gen.sv
// Eight-mode test pattern source with run-time bar width divider and 2-cycle latency.
// Define TEST_PATTERN_BORDER_EN to add a 1-pixel white border over every mode.
module test_pattern_gen #(
    parameter int BIT_WIDTH    = 12,
    parameter int BIT_HEIGHT   = 11,
    parameter int COLOR_DEPTH  = 8,
    parameter int NUM_BARS     = 8,
    parameter int GRID_LOG2    = 5,
    parameter int SCROLL_SHIFT = 2
) (
    input  logic              clk_pixel,
    input  logic              reset,
    test_pattern_gen_if.slave bus
);
    localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int CNT_W = $clog2(BIT_WIDTH + 1);
    localparam int PIX_W = 3 * COLOR_DEPTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} div_state_e;

    div_state_e             state_q, state_d;
    logic                   div_start, div_step, div_load;
    logic [BIT_WIDTH-1:0]   dividend_q, rem_q, quot_q, rem_shift, rem_next;
    logic                   q_bit;
    logic [CNT_W-1:0]       step_q;
    logic [BIT_WIDTH-1:0]   bar_width_q;
    logic                   bars_ready_q;
    logic [2:0]             mode_q;
    logic [15:0]            frame_count_q;
    logic [BIT_WIDTH-1:0]   col_cnt_q, col_cnt_d, cur_cnt;
    logic [IDX_W-1:0]       bar_idx_q, bar_idx_d, cur_idx, scroll_idx;
    logic [16:0]            scroll_sum;
    logic                   fes, active, grid_hit, chk;
    logic [PIX_W-1:0]       c_rgb, s1_rgb_q, out_rgb_q, out_rgb_d;
    logic                   s1_active_q;

    function automatic logic [2:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] expand(input logic [2:0] p);
        return {{COLOR_DEPTH{p[2]}}, {COLOR_DEPTH{p[1]}}, {COLOR_DEPTH{p[0]}}};
    endfunction

    assign fes    = (bus.cx == '0) && (bus.cy == bus.screen_height);
    assign active = (bus.cx < bus.screen_width) && (bus.cy < bus.screen_height);

    // Divider FSM: state register / next state / outputs
    always_ff @(posedge clk_pixel) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fes) state_d = S_DIV;
            S_DIV:   if (!fes && step_q == CNT_W'(BIT_WIDTH - 1)) state_d = S_DONE;
            S_DONE:  state_d = fes ? S_DIV : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_start = fes;
        div_step  = (state_q == S_DIV) && !fes;
        div_load  = (state_q == S_DONE);
    end

    assign rem_shift = {rem_q[BIT_WIDTH-2:0], dividend_q[BIT_WIDTH-1]};
    assign q_bit     = rem_shift >= BIT_WIDTH'(NUM_BARS);
    assign rem_next  = q_bit ? rem_shift - BIT_WIDTH'(NUM_BARS) : rem_shift;

    // A restart only clears the working registers; bar_width_q keeps serving until the load.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            dividend_q   <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            step_q       <= '0;
            bar_width_q  <= '0;
            bars_ready_q <= 1'b0;
        end else begin
            if (div_start) begin
                dividend_q <= bus.screen_width;
                rem_q      <= '0;
                quot_q     <= '0;
                step_q     <= '0;
            end else if (div_step) begin
                dividend_q <= dividend_q << 1;
                rem_q      <= rem_next;
                quot_q     <= {quot_q[BIT_WIDTH-2:0], q_bit};
                step_q     <= step_q + CNT_W'(1);
            end
            if (div_load) begin
                bar_width_q  <= quot_q;
                bars_ready_q <= (quot_q != '0);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mode_q        <= 3'd0;
            frame_count_q <= '0;
        end else if (fes) begin
            mode_q        <= bus.mode;
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    // Bar tracking; the last bar never advances so it absorbs the remainder.
    always_comb begin
        cur_cnt   = (bus.cx == '0) ? '0 : col_cnt_q;
        cur_idx   = (bus.cx == '0) ? '0 : bar_idx_q;
        col_cnt_d = cur_cnt + BIT_WIDTH'(1);
        bar_idx_d = cur_idx;
        if (cur_cnt == bar_width_q - BIT_WIDTH'(1) && cur_idx < IDX_W'(NUM_BARS - 1)) begin
            col_cnt_d = '0;
            bar_idx_d = cur_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            col_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign scroll_sum = 17'(cur_idx) + 17'(frame_count_q >> SCROLL_SHIFT);
    assign scroll_idx = IDX_W'(scroll_sum % 17'(NUM_BARS));
    assign grid_hit   = (bus.cx[GRID_LOG2-1:0] == '0) || (bus.cy[GRID_LOG2-1:0] == '0) ||
                        (bus.cx == bus.screen_width - BIT_WIDTH'(1)) ||
                        (bus.cy == bus.screen_height - BIT_HEIGHT'(1));
    assign chk        = bus.cx[GRID_LOG2] ^ bus.cy[GRID_LOG2] ^ frame_count_q[SCROLL_SHIFT];

    always_comb begin
        c_rgb = '0;
        case (mode_q)
            3'd0:    if (bars_ready_q) c_rgb = expand(palette(3'(cur_idx)));
            3'd1:    c_rgb = expand(grid_hit ? 3'b100 : 3'b000);
            3'd2:    c_rgb = {3{COLOR_DEPTH'(bus.cx)}};
            3'd3:    c_rgb = {bus.in_r, bus.in_g, bus.in_b};
            3'd4:    c_rgb = expand({3{chk}});
            3'd5:    if (bars_ready_q) c_rgb = expand(palette(3'(scroll_idx)));
            3'd6:    c_rgb = {3{COLOR_DEPTH'(bus.cy)}};
            default: c_rgb = expand(3'b001);
        endcase
    end

`ifdef TEST_PATTERN_BORDER_EN
    logic border, s1_border_q;
    assign border = (bus.cx == '0) || (bus.cy == '0) ||
                    (bus.cx == bus.screen_width - BIT_WIDTH'(1)) ||
                    (bus.cy == bus.screen_height - BIT_HEIGHT'(1));

    always_ff @(posedge clk_pixel) begin
        if (reset) s1_border_q <= 1'b0;
        else       s1_border_q <= border;
    end

    always_comb begin
        out_rgb_d = '0;
        if (s1_active_q) out_rgb_d = s1_border_q ? '1 : s1_rgb_q;
    end
`else
    always_comb begin
        out_rgb_d = '0;
        if (s1_active_q) out_rgb_d = s1_rgb_q;
    end
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s1_rgb_q    <= '0;
            s1_active_q <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            s1_rgb_q    <= c_rgb;
            s1_active_q <= active;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign bus.out_r       = out_rgb_q[PIX_W-1 -: COLOR_DEPTH];
    assign bus.out_g       = out_rgb_q[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
    assign bus.out_b       = out_rgb_q[COLOR_DEPTH-1:0];
    assign bus.frame_count = frame_count_q;
    assign bus.bars_ready  = bars_ready_q;
    assign bus.div_state   = state_q;
endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen at 640x480, 8 bars, 8-bit colour.
module tb_test_pattern_gen;
  localparam int BW = 12;
  localparam int BH = 11;
  localparam int CD = 8;
  localparam int H  = 480;

  typedef struct {
    string       name;
    logic [2:0]  mode;
    int          width;
    int          cy;
    int          cx;
    logic [23:0] exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  test_pattern_gen_if #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH), .COLOR_DEPTH(CD)) bus();

  test_pattern_gen #(
    .BIT_WIDTH(BW), .BIT_HEIGHT(BH), .COLOR_DEPTH(CD),
    .NUM_BARS(8), .GRID_LOG2(5), .SCROLL_SHIFT(2)
  ) dut (
    .clk_pixel(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int fc_model = 0;
  logic [23:0] cap [0:1023];
  logic br_obs [0:31];
  logic [1:0] ds_obs [0:31];
  logic [23:0] exp_q[$];
  vec_t vecs[$];

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rgb_now();
    return {bus.out_r, bus.out_g, bus.out_b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // one line at row cy; cap[k] holds the colour produced for column k
  task automatic run_line(input int cy, input int ncx);
    for (int k = 0; k < ncx; k++) begin
      bus.cx = BW'(k);
      bus.cy = BH'(cy);
      tick();
      if (k >= 1) cap[k-1] = rgb_now();
    end
  endtask

  // short frame-end line: FES at cx=0, long enough for the divider to finish
  task automatic fes_line();
    for (int k = 0; k < 20; k++) begin
      bus.cx = BW'(k);
      bus.cy = BH'(H);
      tick();
      br_obs[k] = bus.bars_ready;
      ds_obs[k] = bus.div_state;
    end
    fc_model++;
  endtask

  task automatic add_vec(input string n, input logic [2:0] m, input int w, input int y,
                         input int x, input logic [23:0] e);
    vec_t v;
    v.name = n; v.mode = m; v.width = w; v.cy = y; v.cx = x; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec("bar0_first",   3'd0, 640, 10,   0, 24'hFFFFFF);
    add_vec("bar0_last",    3'd0, 640, 10,  79, 24'hFFFFFF);
    add_vec("bar1_first",   3'd0, 640, 10,  80, 24'hFFFF00);
    add_vec("bar2_cyan",    3'd0, 640, 10, 160, 24'h00FFFF);
    add_vec("bar3_green",   3'd0, 640, 10, 240, 24'h00FF00);
    add_vec("bar4_magenta", 3'd0, 640, 10, 320, 24'hFF00FF);
    add_vec("bar5_red",     3'd0, 640, 10, 400, 24'hFF0000);
    add_vec("bar6_blue",    3'd0, 640, 10, 559, 24'h0000FF);
    add_vec("bar7_black",   3'd0, 640, 10, 560, 24'h000000);
    add_vec("bar7_end",     3'd0, 640, 10, 639, 24'h000000);
    add_vec("w645_bar5",    3'd0, 645, 10, 479, 24'hFF0000);
    add_vec("w645_bar6",    3'd0, 645, 10, 480, 24'h0000FF);
    add_vec("w645_bar7",    3'd0, 645, 10, 644, 24'h000000);
    add_vec("w645_outside", 3'd0, 645, 10, 645, 24'h000000);
    add_vec("grid_x0",      3'd1, 640, 33,   0, 24'hFF0000);
    add_vec("grid_x32",     3'd1, 640, 33,  32, 24'hFF0000);
    add_vec("grid_x64",     3'd1, 640, 33,  64, 24'hFF0000);
    add_vec("grid_x33",     3'd1, 640, 33,  33, 24'h000000);
    add_vec("grid_xlast",   3'd1, 640, 33, 639, 24'hFF0000);
    add_vec("grid_y32",     3'd1, 640, 32,  33, 24'hFF0000);
    add_vec("grid_ylast",   3'd1, 640, 479, 33, 24'hFF0000);
    add_vec("hgray_37",     3'd2, 640, 10,  37, 24'h252525);
    add_vec("hgray_300",    3'd2, 640, 10, 300, 24'h2C2C2C);
    add_vec("solid_100",    3'd3, 640, 10, 100, 24'h123456);
    add_vec("solid_639",    3'd3, 640, 10, 639, 24'h123456);
    add_vec("solid_out",    3'd3, 640, 10, 640, 24'h000000);
    add_vec("vgray_200",    3'd6, 640, 200,  5, 24'hC8C8C8);
    add_vec("blue_0",       3'd7, 640, 10,   0, 24'h0000FF);
    add_vec("blue_vblank",  3'd7, 640, 481, 10, 24'h000000);

    bus.mode = 3'd0; bus.screen_width = BW'(640); bus.screen_height = BH'(H);
    bus.cx = '0; bus.cy = '0;
    bus.in_r = 8'h12; bus.in_g = 8'h34; bus.in_b = 8'h56;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_rgb", 32'(rgb_now()), 32'h0);
    check("rst_fc", 32'(bus.frame_count), 32'h0);
    check("rst_bars_ready", 32'(bus.bars_ready), 32'h0);
    check("rst_div_state", 32'(bus.div_state), 32'h0);
    reset = 1'b0;
    tick();

    // divider timing after the first frame end
    fes_line();
    check("div_state_div", 32'(ds_obs[0]), 32'h1);
    check("bars_ready_before", 32'(br_obs[12]), 32'h0);
    check("bars_ready_after", 32'(br_obs[13]), 32'h1);
    check("fc_first", 32'(bus.frame_count), 32'h1);

    // table of single-pixel vectors; a captured line is reused while the config holds
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].width != vecs[i-1].width ||
          vecs[i].cy != vecs[i-1].cy) begin
        bus.mode = vecs[i].mode;
        bus.screen_width = BW'(vecs[i].width);
        fes_line();
        run_line(vecs[i].cy, vecs[i].width + 4);
      end
      check(vecs[i].name, 32'(cap[vecs[i].cx]), 32'(vecs[i].exp));
    end

    // width narrower than the bar count
    bus.mode = 3'd0; bus.screen_width = BW'(4);
    fes_line();
    check("narrow_bars_ready", 32'(bus.bars_ready), 32'h0);
    run_line(10, 8);
    check("narrow_black", 32'(cap[0]), 32'h0);
    bus.screen_width = BW'(640);

    // mode change mid-frame takes effect after the next frame end
    fes_line();
    run_line(50, 100);
    check("pre_change_bar", 32'(cap[80]), 32'hFFFF00);
    bus.mode = 3'd2;
    run_line(100, 100);
    check("midframe_mode_held", 32'(cap[80]), 32'hFFFF00);
    fes_line();
    run_line(101, 100);
    check("gray_after_fes", 32'(cap[37]), 32'h252525);
    check("gray_after_fes_80", 32'(cap[80]), 32'h505050);

    // checkerboard, phase follows frame_count bit 2
    bus.mode = 3'd4;
    fes_line();
    run_line(0, 100);
    check("chk_a_x0", 32'(cap[0]), (fc_model & 4) ? 32'hFFFFFF : 32'h0);
    check("chk_a_x32", 32'(cap[32]), (fc_model & 4) ? 32'h0 : 32'hFFFFFF);
    repeat (4) fes_line();
    run_line(0, 100);
    check("chk_b_x0", 32'(cap[0]), (fc_model & 4) ? 32'hFFFFFF : 32'h0);

    // reset in the middle of an active line
    bus.mode = 3'd0;
    fes_line();
    bus.mode = 3'd2;
    for (int k = 0; k < 306; k++) begin
      bus.cx = BW'(k);
      bus.cy = BH'(200);
      reset = (k == 300);
      tick();
      if (k == 299) check("pre_rst_green", 32'(rgb_now()), 32'h00FF00);
      if (k == 300) begin
        check("midrst_rgb", 32'(rgb_now()), 32'h0);
        check("midrst_fc", 32'(bus.frame_count), 32'h0);
        check("midrst_bars_ready", 32'(bus.bars_ready), 32'h0);
      end
      if (k == 302) check("post_rst_rgb", 32'(rgb_now()), 32'h0);
    end
    reset = 1'b0;
    fc_model = 0;
    run_line(201, 100);
    check("rst_bars_black", 32'(cap[0]), 32'h0);
    check("rst_mode_bars", 32'(cap[37]), 32'h0);
    bus.mode = 3'd0;
    fes_line();
    check("rst_bars_ready_back", 32'(br_obs[13]), 32'h1);
    run_line(10, 100);
    check("rst_bars_white", 32'(cap[0]), 32'hFFFFFF);

    // scrolling bars: frames 2..8, bar 0 and bar 7 colours
    exp_q = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000,
              24'hFFFF00, 24'hFFFFFF, 24'hFFFF00, 24'hFFFFFF,
              24'hFFFF00, 24'hFFFFFF, 24'hFFFF00, 24'hFFFFFF,
              24'h00FFFF, 24'hFFFF00};
    bus.mode = 3'd5;
    for (int f = 2; f <= 8; f++) begin
      logic [23:0] e0, e7;
      fes_line();
      run_line(10, 610);
      e0 = exp_q.pop_front();
      e7 = exp_q.pop_front();
      check($sformatf("scroll_f%0d_bar0", f), 32'(cap[0]), 32'(e0));
      check($sformatf("scroll_f%0d_bar7", f), 32'(cap[600]), 32'(e7));
    end

    // frame counter wrap: every cycle at cx=0, cy=screen_height is a frame end
    bus.cx = '0;
    bus.cy = BH'(H);
    for (int n = fc_model; n < 65535; n++) tick();
    check("fc_max", 32'(bus.frame_count), 32'hFFFF);
    tick();
    check("fc_wrap", 32'(bus.frame_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
Parametrised successor to the fixed 8-bar/grid/gray pattern source. It sits between the HDMI timing counters (cx/cy) and the TMDS encoder. It generates eight selectable patterns at any resolution, with bar widths computed at run time, frame-synchronous mode switching, and animated patterns driven by an internal frame counter. Output is pipelined with a fixed latency.

Parameters:
BIT_WIDTH, 12, width of cx/screen_width
BIT_HEIGHT, 11, width of cy/screen_height
COLOR_DEPTH, 8, bits per colour channel (4..12)
NUM_BARS, 8, number of colour bars (2..16)
GRID_LOG2, 5, grid pitch = 2**GRID_LOG2 pixels
SCROLL_SHIFT, 2, scrolling/animated patterns advance once per 2**SCROLL_SHIFT frames

Ports:
clk_pixel  in  1  pixel clock
reset  in  1  synchronous, active-high reset
mode  in  3  pattern select, sampled only at frame-end strobe
screen_width  in  BIT_WIDTH  active pixels per line
screen_height  in  BIT_HEIGHT  active lines per frame
cx  in  BIT_WIDTH  current column from timing generator
cy  in  BIT_HEIGHT  current row from timing generator
in_r/in_g/in_b  in  COLOR_DEPTH each  solid-colour input
out_r/out_g/out_b  out  COLOR_DEPTH each  pixel colour
frame_count  out  16  frames since reset, wraps
bars_ready  out  1  bar width valid

Behaviour:
- Single clock domain clk_pixel. Reset is synchronous and active-high. On reset: all outputs 0, frame_count 0, bars_ready 0, latched mode 000, divider idle.
- Latency: out_* corresponds to the cx/cy presented 2 cycles earlier. The latency is identical in every mode.
- Active area: cx < screen_width and cy < screen_height. Outside it, out_* = 0 in every mode.
- Frame-end strobe (FES): cx == 0 and cy == screen_height. On FES:
  - frame_count increments, wrapping from 0xFFFF to 0.
  - mode is latched, so changes mid-frame take effect only at the next frame.
  - screen_width is latched and the divider starts.
- Divider FSM states IDLE -> DIV -> DONE -> IDLE:
  - Restoring divide of latched width by NUM_BARS, one quotient bit per cycle, so DIV lasts BIT_WIDTH cycles.
  - DONE loads bar_width and sets bars_ready=1.
  - A FES arriving while in DIV restarts the division. The old bar_width and bars_ready remain in use until the new result loads.
  - bar_width == 0 (width < NUM_BARS) forces bars_ready=0.
- Bar tracking:
  - At cx==0, column counter=0 and bar index=0.
  - When column counter == bar_width-1 and index < NUM_BARS-1, the index advances and the counter clears.
  - The last bar absorbs the remainder.
- Palette: index i maps to [WHITE,YELLOW,CYAN,GREEN,MAGENTA,RED,BLUE,BLACK][i mod 8]. Full scale = all COLOR_DEPTH bits set.
- Modes:
  - 000: colour bars. Output BLACK if bars_ready=0.
  - 001: grid. RED where cx[GRID_LOG2-1:0]==0, cy[GRID_LOG2-1:0]==0, cx==screen_width-1 or cy==screen_height-1; otherwise BLACK.
  - 010: horizontal gray. Each channel = cx[COLOR_DEPTH-1:0] (cx zero-extended if narrower).
  - 011: solid colour from {in_r,in_g,in_b}, registered in the pipeline.
  - 100: checkerboard. WHITE when cx[GRID_LOG2] ^ cy[GRID_LOG2] ^ frame_count[SCROLL_SHIFT] is set, else BLACK.
  - 101: scrolling bars. Palette index = (bar index + (frame_count >> SCROLL_SHIFT)) mod NUM_BARS. BLACK if bars_ready=0.
  - 110: vertical gray. Each channel = cy[COLOR_DEPTH-1:0].
  - 111: BLUE.
- Reset mid-frame: outputs 0 on the cycle after reset is sampled. Bar modes output BLACK until the first FES plus BIT_WIDTH+1 cycles.

Optional Feature:
TEST_PATTERN_BORDER_EN:
- Defined: a 1-pixel WHITE border overrides every mode at cx==0, cy==0, cx==screen_width-1 and cy==screen_height-1 inside the active area. Latency is unchanged.
- Undefined: no override logic; behaviour is exactly as above.

Test Plan:
- 640x480, NUM_BARS=8, mode 000, two frames -> bars_ready=1 by BIT_WIDTH+1 cycles after the first FES. In frame 2, cx=79 gives WHITE and cx=80 gives YELLOW (each seen 2 cycles later); cx=560..639 give BLACK.
- Width 645, mode 000 -> bar_width=80; bar 7 spans cx 560..644 (85 px); cx=645 outputs 0.
- Mode 000->010 changed at cy=100 -> bars continue to frame end. After FES, cx=37 gives gray 0x25 on all channels.
- Mode 101, SCROLL_SHIFT=2, 640x480 -> bar 0 colour is WHITE for frames 0-3 and YELLOW for frames 4-7. frame_count wraps 0xFFFF->0.
- Reset asserted at cx=300/cy=200 for 1 cycle -> outputs 0, frame_count=0, bars_ready=0. Mode 000 outputs BLACK until the divider completes after the next FES.
- Mode 001, GRID_LOG2=5 -> RED at cx=0,32,64 and cy=32. BLACK at cx=33/cy=33. RED at cx=639.
